rr_arb4: RTL

Four-requester round-robin arbiter that shares a single 4:1 one-bit mux datapath among four sources. It owns the mux select: it decides which requester's input is routed to the mux output and presents that decision as `SEL[1:0]` plus a one-hot grant. It sits directly in front of the 4:1 mux: `SEL` drives the mux `S` port, and requester *n* drives mux input `I[n]`.

---
 rtl/rr_arb4.sv | 117 +++++++++++
 1 files changed

// File: rtl/rr_arb4.sv
// rr_arb4: four-requester round-robin arbiter that owns the select of a shared 4:1 mux.
// Define RR_ARB4_TIMEOUT_EN to limit each owner to MAX_HOLD cycles while others wait.
//
// state  | meaning
// -------+-------------------------------------------------
// S_IDLE | no grant active; SEL keeps the last owner index
// S_OWN  | exactly one GNT bit set; LAST holds the owner
module rr_arb4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic [1:0] SEL,
    output logic       BUSY
);

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t     state;
    logic [1:0] last;
    logic [3:0] cand;
    logic [1:0] pick_idx;
    logic       pick_hit;
    logic [1:0] scan_idx;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arb4: MAX_HOLD must be in 2..255");
    end

    // The current owner is masked out, so one search serves release, timeout and idle.
    always_comb begin
        cand     = REQ & ~GNT;
        pick_idx = 2'd0;
        pick_hit = 1'b0;
        scan_idx = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            scan_idx = last + 2'(i);
            if (!pick_hit && cand[scan_idx]) begin
                pick_hit = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

`ifdef RR_ARB4_TIMEOUT_EN
    localparam logic [7:0] HOLD_END = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            GNT   <= 4'b0000;
            SEL   <= 2'd0;
            BUSY  <= 1'b0;
            last  <= 2'd3;
`ifdef RR_ARB4_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_hit) begin
                        state <= S_OWN;
                        GNT   <= 4'b0001 << pick_idx;
                        SEL   <= pick_idx;
                        BUSY  <= 1'b1;
                        last  <= pick_idx;
`ifdef RR_ARB4_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end
                end
                S_OWN: begin
                    if (!REQ[last]) begin
                        if (pick_hit) begin
                            GNT  <= 4'b0001 << pick_idx;
                            SEL  <= pick_idx;
                            last <= pick_idx;
                        end else begin
                            state <= S_IDLE;
                            GNT   <= 4'b0000;
                            BUSY  <= 1'b0;
                        end
`ifdef RR_ARB4_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end
`ifdef RR_ARB4_TIMEOUT_EN
                    else if (hold_cnt == HOLD_END) begin
                        // A lone owner keeps the grant; the counter restarts either way.
                        if (pick_hit) begin
                            GNT  <= 4'b0001 << pick_idx;
                            SEL  <= pick_idx;
                            last <= pick_idx;
                        end
                        hold_cnt <= 8'd0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                    GNT   <= 4'b0000;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule
